lcd_bus_arbiter: RTL
====================

// Module: lcd_bus_arbiter
// PURPOSE
// - Shares the single 8-bit HD44780-style LCD bus between NUM_REQ write clients, e.g. the sprite/CGRAM updater and the status-text writer.
// - Round-robin arbitration with burst lock: a granted client keeps the bus until it sends its beat flagged last.
// - Generates LCD bus timing on the system clock: setup, enable pulse, hold, then an execution gap before the next beat.
// PARAMETERS
// - NUM_REQ       2      number of requesters (>=2)
// - SETUP_CYC     2      cycles rs/data are stable before lcd_en rises (>=1)
// - EN_CYC        12     cycles lcd_en is held high (>=1)
// - HOLD_CYC      2      cycles rs/data are held after lcd_en falls (>=1)
// - GAP_CYC       2000   execution wait after a normal beat (40 us at 50 MHz)
// - LONG_GAP_CYC  82000  execution wait after a clear/home command (1.64 ms)
// - TIMEOUT_CYC   4096   burst-lock idle limit; used only with LCD_ARB_TIMEOUT_EN
// PORTS
// - clk        in   1          system clock, all logic on rising edge
// - reset      in   1          synchronous, active-low
// - req_valid  in   NUM_REQ    client i has a beat pending
// - req_rs     in   NUM_REQ    rs of client i's beat (0=command, 1=data)
// - req_data   in   8*NUM_REQ  byte of client i, bits [8i+7:8i]
// - req_last   in   NUM_REQ    beat closes client i's burst, releasing the lock
// - req_ready  out  NUM_REQ    one-hot; beat of client i accepted this cycle
// - grant      out  NUM_REQ    one-hot owner of the bus or lock; 0 when free
// - busy       out  1          high in every state except IDLE
// - lcd_rs     out  1          LCD register select
// - lcd_rw     out  1          tied 0, write only
// - lcd_en     out  1          LCD enable strobe
// - lcd_data   out  8          LCD data bus
// - lock_err   out  1          one-cycle pulse on lock timeout; tied 0 when the feature is off
// BEHAVIOUR
// - Reset values: state=IDLE, lcd_en=0, lcd_rs=0, lcd_rw=0, lcd_data=8'h00, grant=0, lock=0, rr_ptr=0, busy=0, lock_err=0.
// - Reset mid-transfer: lcd_en drops on the same edge, the beat is abandoned and the lock is cleared.
// - States: IDLE -> SETUP -> EN_HIGH -> HOLD -> GAP -> IDLE. Each timed state counts exactly its *_CYC cycles.
// - IDLE selection:
//   - Lock held: only the lock owner is eligible.
//   - Lock free: first req_valid at or after rr_ptr, searching upward with wrap-around.
// - Accept handshake:
//   - req_ready[sel] is combinational, high only in IDLE while req_valid[sel]=1.
//   - On that edge: rs/data are captured into lcd_rs/lcd_data, grant=onehot(sel), state -> SETUP.
//   - Clients must hold valid, rs, data and last stable until ready.
//   - Data registers change only on an accept and hold through GAP.
// - Lock rules:
//   - An accepted beat with last=0 sets lock=sel.
//   - An accepted beat with last=1 clears the lock and sets rr_ptr=(sel+1)%NUM_REQ at GAP exit.
//   - While locked, other clients' valid requests are ignored, however long they wait.
// - lcd_en is high only in EN_HIGH, registered and glitch-free.
// - GAP length:
//   - LONG_GAP_CYC when the captured rs=0 and data[7:2]=0 and data!=0 (clear/home commands).
//   - GAP_CYC otherwise.
// - grant returns to 0 at GAP exit unless the lock is held; while locked it stays on the owner.
// - Beat period = 1 + SETUP_CYC + EN_CYC + HOLD_CYC + gap cycles; no new beat is accepted before GAP ends.
// - Simultaneous valid requests with the lock free: the rr_ptr order decides and losers wait.
// - A client dropping valid while unaccepted is legal and takes no effect.
// - Counter widths: $clog2(max(*_CYC)+1); no wrap beyond the terminal count.
// CONFIGURATION
// - LCD_ARB_TIMEOUT_EN defined:
//   - A lock idle counter resets on every owner accept.
//   - If the owner holds req_valid=0 for TIMEOUT_CYC consecutive IDLE cycles, the lock clears and lock_err pulses 1 cycle.
//   - The lock clears, grant becomes 0 and rr_ptr=(owner+1)%NUM_REQ.
// - LCD_ARB_TIMEOUT_EN undefined:
//   - The lock is held indefinitely and lock_err is constant 0.
// TESTING
// - Test parameters: SETUP=1, EN=2, HOLD=1, GAP=4, LONG_GAP=10, TIMEOUT=16.
// - Single beat: client0 valid rs=1 data=8'h41 last=1 -> ready0 for 1 cycle; lcd_en high exactly 2 cycles with lcd_data=8'h41, lcd_rs=1; busy for 8 cycles, next accept possible 9 cycles after the first.
// - Clear gap: client1 rs=0 data=8'h01 -> GAP lasts 10 cycles; data=8'h0C lasts 4; data=8'h00 lasts 4.
// - Burst lock: client0 sends 3 beats, last on the third; client1 valid throughout -> client1 waits for all 3 beats, then accepted; grant sequence 01,01,01,10.
// - Round robin: both clients valid with last=1 on every beat -> accepts alternate 0,1,0,1.
// - Reset during EN_HIGH: reset=0 -> next edge lcd_en=0, grant=0, busy=0; after release, fresh arbitration starts from client0.
// - With LCD_ARB_TIMEOUT_EN: client0 last=0 then valid drops 16 cycles -> lock_err pulse, client1 accepted next; without the macro, client1 is never granted.

Source files
------------

// File: rtl/lcd_bus_arbiter.sv
// Round-robin, burst-locking arbiter that shares one HD44780-style LCD write bus
// and generates its setup/enable/hold/execution-gap timing. Optional lock timeout: LCD_ARB_TIMEOUT_EN.
module lcd_bus_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int SETUP_CYC    = 2,
  parameter int EN_CYC       = 12,
  parameter int HOLD_CYC     = 2,
  parameter int GAP_CYC      = 2000,
  parameter int LONG_GAP_CYC = 82000,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_rs,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic                   lcd_rs,
  output logic                   lcd_rw,
  output logic                   lcd_en,
  output logic [7:0]             lcd_data,
  output logic                   lock_err
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max_of(max_of(max_of(SETUP_CYC, EN_CYC), max_of(HOLD_CYC, GAP_CYC)),
                                  LONG_GAP_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int IDX_W   = $clog2(NUM_REQ);

  localparam logic [CNT_W-1:0] SETUP_LAST    = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST       = CNT_W'(EN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST     = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST      = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_GAP_LAST = CNT_W'(LONG_GAP_CYC - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETUP   = 3'd1;
  localparam logic [2:0] ST_EN_HIGH = 3'd2;
  localparam logic [2:0] ST_HOLD    = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

  if (NUM_REQ < 2 || SETUP_CYC < 1 || EN_CYC < 1 || HOLD_CYC < 1 ||
      GAP_CYC < 1 || LONG_GAP_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("lcd_bus_arbiter: illegal parameter set");
  end

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   gap_last;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   cur_sel;
  logic [IDX_W-1:0]   lock_owner;
  logic [IDX_W-1:0]   sel;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [7:0]         sel_data;
  logic               lock_held;
  logic               beat_last;
  logic               sel_found;
  logic               accept;
  logic               long_gap;
  logic               lock_timeout;

  // Lock owner is the only candidate; otherwise first valid at/after rr_ptr, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel       = '0;
    sel_found = 1'b0;
    if (lock_held) begin
      sel       = lock_owner;
      sel_found = req_valid[lock_owner];
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        idx = 32'(rr_ptr) + i;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!sel_found && req_valid[IDX_W'(idx)]) begin
          sel       = IDX_W'(idx);
          sel_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_onehot      = '0;
    sel_onehot[sel] = 1'b1;
  end

  assign sel_data  = req_data[{sel, 3'b000} +: 8];
  assign accept    = reset && (state == ST_IDLE) && sel_found;
  assign req_ready = accept ? sel_onehot : '0;
  assign busy      = (state != ST_IDLE);
  assign lcd_rw    = 1'b0;

  // Clear display / return home need the long execution wait.
  assign long_gap = !lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data != 8'h00);
  assign gap_last = long_gap ? LONG_GAP_LAST : GAP_LAST;

`ifdef LCD_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  logic [TO_W-1:0] idle_cnt;
  logic            owner_idle;

  assign owner_idle   = (state == ST_IDLE) && lock_held && !req_valid[lock_owner];
  assign lock_timeout = owner_idle && (idle_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      lock_err <= lock_timeout;
      if (!lock_held || accept || lock_timeout) begin
        idle_cnt <= '0;
      end else if (owner_idle) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  assign lock_timeout = 1'b0;
  assign lock_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      lcd_en     <= 1'b0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      grant      <= '0;
      lock_held  <= 1'b0;
      lock_owner <= '0;
      rr_ptr     <= '0;
      cur_sel    <= '0;
      beat_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            lcd_rs    <= req_rs[sel];
            lcd_data  <= sel_data;
            grant     <= sel_onehot;
            cur_sel   <= sel;
            beat_last <= req_last[sel];
            cnt       <= '0;
            state     <= ST_SETUP;
            // A closing beat keeps any existing lock until the gap has elapsed.
            if (!req_last[sel]) begin
              lock_held  <= 1'b1;
              lock_owner <= sel;
            end
          end else if (lock_timeout) begin
            lock_held <= 1'b0;
            grant     <= '0;
            rr_ptr    <= next_idx(lock_owner);
          end
        end
        ST_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt    <= '0;
            lcd_en <= 1'b1;
            state  <= ST_EN_HIGH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_EN_HIGH: begin
          if (cnt == EN_LAST) begin
            cnt    <= '0;
            lcd_en <= 1'b0;
            state  <= ST_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= ST_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == gap_last) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (beat_last) begin
              lock_held <= 1'b0;
              grant     <= '0;
              rr_ptr    <= next_idx(cur_sel);
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          lcd_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
